// File: rtl/fetch_redirect.sv
// Instruction fetch front end: PC sequencing, one-entry skid buffer, and EX-stage branch redirect.
// Optional build macro FETCH_PERF_EN adds redirect / stall-cycle performance counters.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_taken,
    input  logic [31:0] pc_bru,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, PEND} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] tgt_reg;
    logic        sk_valid_reg;
    logic [31:0] sk_pc_reg;
    logic [31:0] sk_inst_reg;
    logic [31:0] target;
    logic        accept;
    logic        fetch_ok;

    assign target    = {pc_bru[31:2], 2'b00};
    assign imem_addr = pc_reg;
    assign flush_id  = is_taken;
    assign flush_ex  = is_taken;
    assign accept    = imem_req & imem_gnt;
    // Only a sequential-path grant in REQ yields a usable instruction.
    assign fetch_ok  = accept && (state_reg == REQ) && !is_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = ~sk_valid_reg;
                if (is_taken && imem_req && !imem_gnt) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC and pending redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= RESET_PC;
            tgt_reg <= 32'h0;
        end else begin
            case (state_reg)
                REQ: begin
                    if (is_taken) begin
                        if (imem_req && !imem_gnt) begin
                            tgt_reg <= target;
                        end else begin
                            pc_reg <= target;
                        end
                    end else if (accept) begin
                        pc_reg <= pc_reg + 32'd4;
                    end
                end
                PEND: begin
                    // The wrong-path grant is swallowed; the newest target wins.
                    if (is_taken && imem_gnt) begin
                        pc_reg <= target;
                    end else if (is_taken) begin
                        tgt_reg <= target;
                    end else if (imem_gnt) begin
                        pc_reg <= tgt_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // IF/ID output register and skid buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_inst      <= 32'h0;
            sk_valid_reg <= 1'b0;
            sk_pc_reg    <= 32'h0;
            sk_inst_reg  <= 32'h0;
        end else if (is_taken) begin
            if_valid     <= 1'b0;
            sk_valid_reg <= 1'b0;
        end else if (!stall) begin
            if (sk_valid_reg) begin
                if_valid     <= 1'b1;
                if_pc        <= sk_pc_reg;
                if_inst      <= sk_inst_reg;
                sk_valid_reg <= 1'b0;
            end else if (fetch_ok) begin
                if_valid <= 1'b1;
                if_pc    <= pc_reg;
                if_inst  <= imem_rdata;
            end else begin
                if_valid <= 1'b0;
            end
        end else if (fetch_ok) begin
            sk_valid_reg <= 1'b1;
            sk_pc_reg    <= pc_reg;
            sk_inst_reg  <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] redirects_reg;
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirects_reg    <= 32'h0;
            stall_cycles_reg <= 32'h0;
        end else begin
            if (is_taken) begin
                redirects_reg <= redirects_reg + 32'd1;
            end
            if (stall) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_redirects    = redirects_reg;
    assign perf_stall_cycles = stall_cycles_reg;
`else
    assign perf_redirects    = 32'h0;
    assign perf_stall_cycles = 32'h0;
`endif

endmodule
